// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, reads the opcode word
// and its 0-2 extension words from instruction memory, and presents the
// bundle to the control unit through a valid/ack handshake. Conditional
// jumps are resolved against the status flags when the bundle is consumed.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   output logic [15:0] instruction,
   output logic [15:0] instruction_1,
   output logic [15:0] instruction_2,
   output logic        instr_valid,
   input  logic        instr_ack,
   input  logic [3:0]  flags,
   input  logic        pc_load,
   input  logic [15:0] pc_load_val,
   output logic [15:0] pc
);

   localparam int DATA_W = 16;
   localparam logic [DATA_W-1:0] PC_INIT = RESET_PC & 16'hFFFE;
   localparam logic [DATA_W-1:0] WORD_STEP = 16'd2;

   typedef enum logic [1:0] {
      READ_OP   = 2'd0,
      READ_EXT1 = 2'd1,
      READ_EXT2 = 2'd2,
      HOLD      = 2'd3
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [1:0]        ext_cnt;
   logic              rd_block;
   logic              rd_fire;
   logic              jump_take;
   logic [DATA_W-1:0] load_target;
   logic [DATA_W-1:0] jump_target;
   logic [DATA_W-1:0] pc_plus2;

   // Source operand needs an extension word for indexed/absolute/symbolic
   // (As=01, except the constant generator on R3) and immediate (As=11, R0).
   function automatic logic src_ext(input logic [1:0] as, input logic [3:0] rsel);
      return ((as == 2'b01) && (rsel != 4'd3)) || ((as == 2'b11) && (rsel == 4'd0));
   endfunction

   function automatic logic is_jump(input logic [15:0] w);
      return (w[15:13] == 3'b001);
   endfunction

   // Number of extension words following an opcode word.
   function automatic logic [1:0] ext_words(input logic [15:0] w);
      logic [1:0] n;
      n = 2'd0;
      if (is_jump(w)) begin
         n = 2'd0;
      end else if (w[15:10] == 6'b000100) begin
         n = {1'b0, src_ext(w[5:4], w[3:0])};
      end else if (w[15:12] >= 4'd4) begin
         n = {1'b0, src_ext(w[5:4], w[11:8])} + {1'b0, w[7]};
      end
      return n;
   endfunction

   // Jump condition; flags are {V,N,Z,C}.
   function automatic logic jump_cond(input logic [2:0] cond, input logic [3:0] f);
      logic v, n, z, c, t;
      v = f[3];
      n = f[2];
      z = f[1];
      c = f[0];
      case (cond)
         3'b000:  t = ~z;
         3'b001:  t = z;
         3'b010:  t = ~c;
         3'b011:  t = c;
         3'b100:  t = n;
         3'b101:  t = ~(n ^ v);
         3'b110:  t = n ^ v;
         default: t = 1'b1;
      endcase
      return t;
   endfunction

   // Word offset of a jump, sign-extended and scaled to bytes.
   function automatic logic signed [DATA_W-1:0] jump_offset(input logic [15:0] w);
      logic signed [DATA_W-1:0] off;
      off = {{5{w[9]}}, w[9:0], 1'b0};
      return off;
   endfunction

   // A read is requested in every fetch state unless the cycle right after a
   // reset or PC load is blocked, which discards any in-flight access.
   assign mem_rd      = (state != HOLD) && !rd_block;
   assign mem_addr    = pc;
   assign rd_fire     = mem_rd && mem_ready;
   assign instr_valid = (state == HOLD);
   assign load_target = pc_load_val & 16'hFFFE;
   assign pc_plus2    = pc + WORD_STEP;
   assign jump_target = pc + $unsigned(jump_offset(instruction));
   assign jump_take   = is_jump(instruction) && jump_cond(instruction[12:10], flags);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= READ_OP;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a PC load overrides whatever the sequencer was doing.
   always_comb begin
      state_next = state;
      case (state)
         READ_OP: begin
            if (rd_fire) begin
               state_next = (ext_words(mem_rdata) == 2'd0) ? HOLD : READ_EXT1;
            end
         end
         READ_EXT1: begin
            if (rd_fire) begin
               state_next = (ext_cnt == 2'd2) ? READ_EXT2 : HOLD;
            end
         end
         READ_EXT2: begin
            if (rd_fire) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (instr_ack) begin
               state_next = READ_OP;
            end
         end
         default: state_next = READ_OP;
      endcase
      if (pc_load) begin
         state_next = READ_OP;
      end
   end

   // PC, captured words and read blocking; reset and PC load take priority
   // so a pending read can never be captured after either.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= PC_INIT;
         instruction   <= '0;
         instruction_1 <= '0;
         instruction_2 <= '0;
         ext_cnt       <= 2'd0;
         rd_block      <= 1'b1;
      end else if (pc_load) begin
         pc       <= load_target;
         rd_block <= 1'b1;
      end else begin
         rd_block <= 1'b0;
         case (state)
            READ_OP: begin
               if (rd_fire) begin
                  instruction   <= mem_rdata;
                  instruction_1 <= '0;
                  instruction_2 <= '0;
                  ext_cnt       <= ext_words(mem_rdata);
                  pc            <= pc_plus2;
               end
            end
            READ_EXT1: begin
               if (rd_fire) begin
                  instruction_1 <= mem_rdata;
                  pc            <= pc_plus2;
               end
            end
            READ_EXT2: begin
               if (rd_fire) begin
                  instruction_2 <= mem_rdata;
                  pc            <= pc_plus2;
               end
            end
            HOLD: begin
               if (instr_ack && jump_take) begin
                  pc <= jump_target;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a word-addressed memory model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic [15:0] instruction;
   logic [15:0] instruction_1;
   logic [15:0] instruction_2;
   logic        instr_valid;
   logic        instr_ack;
   logic [3:0]  flags;
   logic        pc_load;
   logic [15:0] pc_load_val;
   logic [15:0] pc;

   logic [15:0] mem [0:32767];

   int checks = 0;
   int errors = 0;

   fetch_unit #(.RESET_PC(16'h0000)) dut (
      .clk(clk),
      .rst(rst),
      .mem_addr(mem_addr),
      .mem_rd(mem_rd),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .instruction(instruction),
      .instruction_1(instruction_1),
      .instruction_2(instruction_2),
      .instr_valid(instr_valid),
      .instr_ack(instr_ack),
      .flags(flags),
      .pc_load(pc_load),
      .pc_load_val(pc_load_val),
      .pc(pc)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[15:1]];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic load_pc(input logic [15:0] val);
      pc_load     = 1'b1;
      pc_load_val = val;
      step();
      pc_load = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!instr_valid && n < 20) begin
         step();
         n++;
      end
      chk(tag, {15'd0, instr_valid}, 16'd1);
   endtask

   task automatic ack();
      instr_ack = 1'b1;
      step();
      instr_ack = 1'b0;
   endtask

   // Fetch a one-word jump placed at 0x0010, consume it, check the next address.
   task automatic jump_case(input string tag, input logic [15:0] word,
                            input logic [3:0] f, input logic [15:0] exp_addr);
      mem[8] = word;
      flags  = f;
      load_pc(16'h0010);
      wait_valid({tag, "_valid"});
      chk({tag, "_pc_hold"}, pc, 16'h0012);
      ack();
      chk({tag, "_addr"}, mem_addr, exp_addr);
      chk({tag, "_rd"}, {15'd0, mem_rd}, 16'd1);
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 16'h4405;
      rst         = 1'b1;
      mem_ready   = 1'b1;
      instr_ack   = 1'b0;
      flags       = 4'b0000;
      pc_load     = 1'b0;
      pc_load_val = 16'h0000;

      // Reset state
      step();
      step();
      chk("rst_valid", {15'd0, instr_valid}, 16'd0);
      chk("rst_instr", instruction, 16'h0000);
      chk("rst_instr1", instruction_1, 16'h0000);
      chk("rst_instr2", instruction_2, 16'h0000);
      chk("rst_pc", pc, 16'h0000);
      chk("rst_rd", {15'd0, mem_rd}, 16'd0);

      // Single-word MOV R4,R5
      rst = 1'b0;
      step();
      chk("t1_rd", {15'd0, mem_rd}, 16'd1);
      chk("t1_addr", mem_addr, 16'h0000);
      step();
      chk("t1_valid", {15'd0, instr_valid}, 16'd1);
      chk("t1_instr", instruction, 16'h4405);
      chk("t1_instr1", instruction_1, 16'h0000);
      chk("t1_instr2", instruction_2, 16'h0000);
      chk("t1_pc", pc, 16'h0002);
      chk("t1_hold_rd", {15'd0, mem_rd}, 16'd0);
      ack();
      chk("t1_ack_valid", {15'd0, instr_valid}, 16'd0);

      // Three-word MOV #0x1234,4(R5) with a stalled second word
      mem[0] = 16'h40B5;
      mem[1] = 16'h1234;
      mem[2] = 16'h0004;
      do_reset();
      step();
      chk("t2_op_pc", pc, 16'h0002);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_stall_pc", pc, 16'h0002);
         chk("t2_stall_instr", instruction, 16'h40B5);
         chk("t2_stall_addr", mem_addr, 16'h0002);
         chk("t2_stall_valid", {15'd0, instr_valid}, 16'd0);
      end
      mem_ready = 1'b1;
      wait_valid("t2_valid");
      chk("t2_instr", instruction, 16'h40B5);
      chk("t2_instr1", instruction_1, 16'h1234);
      chk("t2_instr2", instruction_2, 16'h0004);
      chk("t2_pc", pc, 16'h0006);
      ack();

      // Jumps resolved at ack
      jump_case("jmp", 16'h3C05, 4'b0000, 16'h001C);
      jump_case("jeq_nz", 16'h2405, 4'b0000, 16'h0012);
      jump_case("jeq_z", 16'h2405, 4'b0010, 16'h001C);
      jump_case("jge_nt", 16'h3405, 4'b0100, 16'h0012);
      jump_case("jmp_self", 16'h3FFF, 4'b0000, 16'h0010);

      // PC wraparound
      load_pc(16'hFFFE);
      wait_valid("wrap_valid");
      chk("wrap_pc", pc, 16'h0000);
      ack();
      chk("wrap_addr", mem_addr, 16'h0000);

      // PC load while an extension read is stalled
      mem[16'h0100] = 16'h4405;
      do_reset();
      step();
      mem_ready = 1'b0;
      step();
      pc_load     = 1'b1;
      pc_load_val = 16'h0201;
      step();
      pc_load = 1'b0;
      chk("ld_pc", pc, 16'h0200);
      chk("ld_valid", {15'd0, instr_valid}, 16'd0);
      chk("ld_rd", {15'd0, mem_rd}, 16'd0);
      mem_ready = 1'b1;
      step();
      chk("ld_rd2", {15'd0, mem_rd}, 16'd1);
      chk("ld_addr", mem_addr, 16'h0200);
      wait_valid("ld_bundle_valid");
      chk("ld_instr", instruction, 16'h4405);
      chk("ld_instr1", instruction_1, 16'h0000);
      chk("ld_pc2", pc, 16'h0202);
      ack();

      // PC load coincident with ack of a taken jump
      mem[8] = 16'h3C05;
      load_pc(16'h0010);
      wait_valid("ldack_valid");
      instr_ack   = 1'b1;
      pc_load     = 1'b1;
      pc_load_val = 16'h0200;
      step();
      instr_ack = 1'b0;
      pc_load   = 1'b0;
      chk("ldack_pc", pc, 16'h0200);
      chk("ldack_valid", {15'd0, instr_valid}, 16'd0);

      // Reset while holding a bundle
      wait_valid("hrst_pre");
      rst = 1'b1;
      step();
      chk("hrst_valid", {15'd0, instr_valid}, 16'd0);
      chk("hrst_instr", instruction, 16'h0000);
      chk("hrst_pc", pc, 16'h0000);
      chk("hrst_rd", {15'd0, mem_rd}, 16'd0);

      // Reset during a pending extension read
      rst = 1'b0;
      step();
      step();
      chk("mrst_pre_instr", instruction, 16'h40B5);
      mem_ready = 1'b0;
      step();
      rst       = 1'b1;
      mem_ready = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_instr", instruction, 16'h0000);
      chk("mrst_instr1", instruction_1, 16'h0000);
      chk("mrst_instr2", instruction_2, 16'h0000);
      chk("mrst_pc", pc, 16'h0000);
      chk("mrst_rd", {15'd0, mem_rd}, 16'd0);
      chk("mrst_valid", {15'd0, instr_valid}, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
